// File: rtl/myproject_sdiv_19s_8ns_11_seq.sv
// Sequential radix-2 restoring divider: 19-bit signed dividend by 8-bit unsigned divisor,
// producing a saturated 11-bit signed quotient and a 9-bit signed remainder.
module myproject_sdiv_19s_8ns_11_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 19,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 11
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    din_vld,
  output logic                    din_rdy,
  input  logic [din0_WIDTH-1:0]   din0,
  input  logic [din1_WIDTH-1:0]   din1,
  output logic                    dout_vld,
  input  logic                    dout_rdy,
  output logic [dout_WIDTH-1:0]   quot,
  output logic [din1_WIDTH:0]     rem,
  output logic                    ovf,
  output logic                    div0
);

  localparam int DW = din0_WIDTH;
  localparam int VW = din1_WIDTH;
  localparam int QW = dout_WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};
  localparam logic [DW-1:0] MAG_POS = {{(DW-QW){1'b0}}, Q_MAX};
  localparam logic [DW-1:0] MAG_NEG = {{(DW-QW){1'b0}}, Q_MIN};
  localparam logic [CW-1:0] ITER_LAST = CW'(DW-1);

  // Instance tag only; a negative value is simply an empty generate branch.
  if (ID < 0) begin : g_id_tag
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_dvd;    // remaining dividend bits at top, quotient bits shifted in at bottom
  logic [VW-1:0]   r_prem;
  logic [VW-1:0]   r_dvs;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic            r_fin;
  logic [QW-1:0]   r_quot;
  logic [VW:0]     r_rem;
  logic            r_ovf;
  logic            r_div0;

  logic            w_accept;
  logic [DW-1:0]   w_abs;
  logic [VW:0]     w_trial;
  logic [VW:0]     w_sub;
  logic            w_ge;
  logic            w_dz;
  logic            w_ovf;
  logic            w_sat;
  logic [QW-1:0]   w_quot;
  logic [VW:0]     w_rem;

  assign din_rdy  = (r_state == IDLE) && !ap_rst;
  assign dout_vld = (r_state == DONE);
  assign w_accept = din_vld && din_rdy;
  assign w_abs    = din0[DW-1] ? (~din0 + 1'b1) : din0;

  assign w_trial = {r_prem, r_dvd[DW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_sub   = w_trial - {1'b0, r_dvs};

  // Finalise: a negative quotient may reach magnitude 2^(QW-1) without saturating.
  assign w_dz    = (r_dvs == '0);
  assign w_ovf   = !w_dz && (r_neg ? (r_dvd > MAG_NEG) : (r_dvd > MAG_POS));
  assign w_sat   = w_dz || w_ovf;
  assign w_quot  = w_sat ? (r_neg ? Q_MIN : Q_MAX)
                         : (r_neg ? (~r_dvd[QW-1:0] + 1'b1) : r_dvd[QW-1:0]);
  assign w_rem   = w_dz ? '0 : (r_neg ? (~{1'b0, r_prem} + 1'b1) : {1'b0, r_prem});

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (r_fin)    w_next = DONE;
      DONE:    if (dout_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_prem  <= '0;
      r_dvs   <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_accept) begin
        r_dvd  <= w_abs;
        r_prem <= '0;
        r_dvs  <= din1;
        r_neg  <= din0[DW-1];
        r_cnt  <= ITER_LAST;
        r_fin  <= 1'b0;
        r_quot <= '0;
        r_rem  <= '0;
        r_ovf  <= 1'b0;
        r_div0 <= 1'b0;
      end else if (r_state == CALC) begin
        if (!r_fin) begin
          r_prem <= w_ge ? w_sub[VW-1:0] : w_trial[VW-1:0];
          r_dvd  <= {r_dvd[DW-2:0], w_ge};
          if (r_cnt == '0) r_fin <= 1'b1;
          else             r_cnt <= r_cnt - 1'b1;
        end else begin
          r_fin  <= 1'b0;
          r_quot <= w_quot;
          r_rem  <= w_rem;
          r_ovf  <= w_ovf;
          r_div0 <= w_dz;
        end
      end
    end
  end

  assign quot = r_quot;
  assign rem  = r_rem;
  assign ovf  = r_ovf;
  assign div0 = r_div0;

endmodule

// File: tb/tb_myproject_sdiv_19s_8ns_11_seq.sv
// Directed bench for the sequential 19s/8ns divider, plus a short random sweep with round-trip check.
module tb_myproject_sdiv_19s_8ns_11_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic [18:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic        dout_vld;
  logic        dout_rdy = 1'b0;
  logic [10:0] quot;
  logic [8:0]  rem;
  logic        ovf;
  logic        div0;

  int n_vec = 0;
  int n_err = 0;

  myproject_sdiv_19s_8ns_11_seq #(.ID(1), .din0_WIDTH(19), .din1_WIDTH(8), .dout_WIDTH(11)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .din_vld(din_vld), .din_rdy(din_rdy),
    .din0(din0), .din1(din1), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .quot(quot), .rem(rem), .ovf(ovf), .div0(div0)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 60 && !din_rdy; i++) tick();
  endtask

  // Issue one operation, wait for the result, capture it and pop it.
  task automatic run(input int a, input int b, output int q, output int r,
                     output int o, output int z, output int lat);
    wait_rdy();
    din_vld = 1'b1;
    din0 = a[18:0];
    din1 = b[7:0];
    tick();
    din_vld = 1'b0;
    lat = 0;
    while (!dout_vld && lat < 60) begin
      tick();
      lat++;
    end
    q = $signed(quot);
    r = $signed(rem);
    o = ovf;
    z = div0;
    dout_rdy = 1'b1;
    tick();
    dout_rdy = 1'b0;
  endtask

  task automatic op(input string tag, input int a, input int b,
                    input int eq, input int er, input int eo, input int ez);
    int q, r, o, z, lat;
    run(a, b, q, r, o, z, lat);
    chk({tag, "_lat"}, lat, 20);
    chk({tag, "_quot"}, q, eq);
    chk({tag, "_rem"}, r, er);
    chk({tag, "_ovf"}, o, eo);
    chk({tag, "_div0"}, z, ez);
  endtask

  task automatic rand_op(input int a, input int b);
    int q, r, o, z, lat;
    int eq, er, eo, ez, qt;
    if (b == 0) begin
      eq = (a >= 0) ? 1023 : -1024;
      er = 0; eo = 0; ez = 1;
    end else begin
      qt = a / b;
      er = a % b;
      ez = 0;
      eo = (qt > 1023 || qt < -1024) ? 1 : 0;
      eq = (qt > 1023) ? 1023 : (qt < -1024) ? -1024 : qt;
    end
    run(a, b, q, r, o, z, lat);
    chk("rnd_lat", lat, 20);
    chk("rnd_quot", q, eq);
    chk("rnd_rem", r, er);
    chk("rnd_ovf", o, eo);
    chk("rnd_div0", z, ez);
    if (o == 0 && z == 0) chk("rnd_rtrip", q * b + r, a);
  endtask

  initial begin
    int seen, a, b, lat;

    // Reset state
    repeat (3) tick();
    chk("rst_din_rdy", din_rdy, 0);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_div0", div0, 0);
    ap_rst = 1'b0;
    #1;
    chk("rel_din_rdy", din_rdy, 1);

    // Basic, sign handling, saturation and divide-by-zero
    op("t1",       1000,  10,   100,  0, 0, 0);
    op("t2_neg",  -1234,   7,  -176, -2, 0, 0);
    op("t2_pos",   1234,   7,   176,  2, 0, 0);
    op("t3_pmax", 262143,  1,  1023,  0, 1, 0);
    op("t3_nmin", -262144, 1, -1024,  0, 1, 0);
    op("t3_nexact", -10240, 10, -1024, 0, 0, 0);
    op("t3_pexact", 260865, 255, 1023, 0, 0, 0);
    op("t3_povrem", 262143, 255, 1023, 3, 1, 0);
    op("t3_zero",      0,   5,     0,  0, 0, 0);
    op("t4_pos",     500,   0,  1023,  0, 0, 1);
    op("t4_neg",      -5,   0, -1024,  0, 0, 1);

    // Backpressure hold and ignored din_vld during CALC
    wait_rdy();
    din_vld = 1'b1; din0 = 19'd1234; din1 = 8'd7;
    tick();
    din_vld = 1'b0;
    repeat (4) tick();
    din_vld = 1'b1; din0 = 19'd5; din1 = 8'd1;
    tick();
    din_vld = 1'b0;
    lat = 5;
    while (!dout_vld && lat < 60) begin
      tick();
      lat++;
    end
    chk("t5_lat", lat, 20);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_vld", dout_vld, 1);
      chk("t5_hold_quot", $signed(quot), 176);
      chk("t5_hold_rem", $signed(rem), 2);
      chk("t5_hold_ovf", ovf, 0);
      chk("t5_din_rdy", din_rdy, 0);
      tick();
    end
    dout_rdy = 1'b1;
    tick();
    dout_rdy = 1'b0;
    chk("t5_vld_drop", dout_vld, 0);
    seen = 0;
    repeat (30) begin
      tick();
      if (dout_vld) seen = 1;
    end
    chk("t5_no_extra", seen, 0);

    // Reset mid-operation aborts the result
    wait_rdy();
    din_vld = 1'b1; din0 = 19'd1000; din1 = 8'd10;
    tick();
    din_vld = 1'b0;
    repeat (10) tick();
    ap_rst = 1'b1;
    tick();
    chk("t6_rst_rdy", din_rdy, 0);
    chk("t6_rst_vld", dout_vld, 0);
    ap_rst = 1'b0;
    #1;
    chk("t6_rel_rdy", din_rdy, 1);
    seen = 0;
    repeat (25) begin
      tick();
      if (dout_vld) seen = 1;
    end
    chk("t6_no_vld", seen, 0);
    op("t6_after", 1000, 10, 100, 0, 0, 0);

    // Random sweep against a behavioural model
    for (int i = 0; i < 300; i++) begin
      b = $urandom_range(0, 255);
      if (i % 2 == 0) a = int'($urandom_range(0, 524287)) - 262144;
      else            a = int'($urandom_range(0, 2 * b * 1024)) - b * 1024;
      rand_op(a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
